// File: rtl/clock_ctrl_pkg.sv
// Shared constants and state encoding for the digital-clock sequencer.
package clock_ctrl_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_HOURS = 2'd1;
  localparam logic [1:0] ST_SET_MINS  = 2'd2;

  localparam int                SECS_W   = 6;
  localparam logic [SECS_W-1:0] SECS_MAX = 6'd59;

  typedef enum logic [1:0] {
    S_RUN       = ST_RUN,
    S_SET_HOURS = ST_SET_HOURS,
    S_SET_MINS  = ST_SET_MINS
  } state_e;

endpackage

// File: rtl/clock_ctrl_if.sv
// Board-side bundle of the clock sequencer: buttons and carry status in,
// counter enables and display state out.
interface clock_ctrl_if;
  import clock_ctrl_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic              mins_at_max;
  logic              inc_mins;
  logic              inc_hours;
  logic [SECS_W-1:0] seconds;
  logic              set_hours_active;
  logic              set_mins_active;
  logic              blink;

  modport master (
    output btn_mode, btn_inc, mins_at_max,
    input  inc_mins, inc_hours, seconds, set_hours_active, set_mins_active, blink
  );

  modport slave (
    input  btn_mode, btn_inc, mins_at_max,
    output inc_mins, inc_hours, seconds, set_hours_active, set_mins_active, blink
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
// rise is combinational from the input and the previous-cycle register.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= in;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Digital-clock sequencer: 1 Hz timebase, seconds count, time-set FSM and
// single-cycle minute/hour enables. AUTO_REPEAT_EN adds held-button auto-repeat.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int SET_TIMEOUT_S = 10,
  parameter int HOLD_CYCLES   = CLK_HZ / 2,
  parameter int REPEAT_CYCLES = CLK_HZ / 8
) (
  input  logic        clk,
  input  logic        reset_n,
  clock_ctrl_if.slave bus
);

  localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int             TW         = (SET_TIMEOUT_S > 1) ? $clog2(SET_TIMEOUT_S + 1) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]  PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(SET_TIMEOUT_S - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              inc_mins_q, inc_mins_d;
  logic              inc_hours_q, inc_hours_d;
  logic              blink_q;

  logic rise_mode, rise_inc;
  logic tick, tmo_expire, in_set, rep_fire;

  edge_detect u_edge_mode (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.btn_mode),
    .rise    (rise_mode)
  );

  edge_detect u_edge_inc (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.btn_inc),
    .rise    (rise_inc)
  );

  assign tick       = (presc_q == PRESC_LAST);
  assign in_set     = (state_q != S_RUN);
  assign tmo_expire = (SET_TIMEOUT_S != 0) && tick && (tmo_q == TMO_LAST);

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_arm_q, rep_arm_d;
  logic          rep_on_q, rep_on_d;

  // Repeat only follows a rise seen inside a set state, never a level carried in from RUN.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    rep_on_d  = rep_on_q;
    rep_fire  = 1'b0;
    if (!in_set || !bus.btn_inc || rise_mode) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
      rep_on_d  = 1'b0;
    end else if (rise_inc) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b1;
      rep_on_d  = 1'b0;
    end else if (rep_arm_q) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
      if (!rep_on_q && rep_cnt_q == RW'(HOLD_CYCLES - 1)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
        rep_on_d  = 1'b1;
      end else if (rep_on_q && rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
      rep_on_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
      rep_on_q  <= rep_on_d;
    end
  end
`else
  logic unused_rep_cfg;
  assign rep_fire       = 1'b0;
  assign unused_rep_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    secs_d      = secs_q;
    tmo_d       = tmo_q;
    inc_mins_d  = 1'b0;
    inc_hours_d = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (rise_mode) begin
          state_d = S_SET_HOURS;
          tmo_d   = '0;
        end
        if (tick) begin
          if (secs_q == SECS_MAX) begin
            secs_d      = '0;
            inc_mins_d  = 1'b1;
            inc_hours_d = bus.mins_at_max;
          end else begin
            secs_d = secs_q + 1'b1;
          end
        end
      end
      S_SET_HOURS, S_SET_MINS: begin
        // Mode edge has priority; a simultaneous inc edge is dropped.
        if (rise_mode) begin
          tmo_d = '0;
          if (state_q == S_SET_HOURS) begin
            state_d = S_SET_MINS;
          end else begin
            state_d = S_RUN;
            secs_d  = '0;
            presc_d = '0;
          end
        end else if (rise_inc || rep_fire) begin
          tmo_d = '0;
          if (state_q == S_SET_HOURS) inc_hours_d = 1'b1;
          else                        inc_mins_d  = 1'b1;
        end else if (tmo_expire) begin
          state_d = S_RUN;
          secs_d  = '0;
          presc_d = '0;
          tmo_d   = '0;
        end else if (tick && SET_TIMEOUT_S != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      presc_q     <= '0;
      secs_q      <= '0;
      tmo_q       <= '0;
      inc_mins_q  <= 1'b0;
      inc_hours_q <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      secs_q      <= secs_d;
      tmo_q       <= tmo_d;
      inc_mins_q  <= inc_mins_d;
      inc_hours_q <= inc_hours_d;
      blink_q     <= (presc_q < PRESC_HALF);
    end
  end

  assign bus.inc_mins         = inc_mins_q;
  assign bus.inc_hours        = inc_hours_q;
  assign bus.seconds          = secs_q;
  assign bus.set_hours_active = (state_q == S_SET_HOURS);
  assign bus.set_mins_active  = (state_q == S_SET_MINS);
  assign bus.blink            = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl at CLK_HZ=4: one instance with a long set
// timeout, a second with SET_TIMEOUT_S=2 sharing the same button stimulus.
module tb_clock_ctrl;

  localparam int HZ   = 4;
  localparam int HOLD = 6;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  clock_ctrl_if ifa();
  clock_ctrl_if ifb();

  assign ifb.btn_mode    = ifa.btn_mode;
  assign ifb.btn_inc     = ifa.btn_inc;
  assign ifb.mins_at_max = ifa.mins_at_max;

  clock_ctrl #(.CLK_HZ(HZ), .SET_TIMEOUT_S(10), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );

  clock_ctrl #(.CLK_HZ(HZ), .SET_TIMEOUT_S(2), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_tmo (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    ifa.btn_mode = 1'b0;
    ifa.btn_inc = 1'b0;
    ifa.mins_at_max = 1'b0;
    #3;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic mode_press();
    ifa.btn_mode = 1'b1;
    step();
    ifa.btn_mode = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [4:0] bobs;
    logic [4:0] bexp;
    bexp = 5'b10011;
    apply_reset();
    checks++;
    if ({ifa.inc_mins, ifa.inc_hours, ifa.set_hours_active, ifa.set_mins_active, ifa.blink} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b expected 00000",
        {ifa.inc_mins, ifa.inc_hours, ifa.set_hours_active, ifa.set_mins_active, ifa.blink}); end
    checks++;
    if (ifa.seconds !== 6'd0) begin errors++; $display("FAIL reset_seconds: got %0d expected 0", ifa.seconds); end
    for (int k = 0; k < 5; k++) begin
      step();
      bobs[k] = ifa.blink;
      if (k == 3) begin
        checks++;
        if (ifa.seconds !== 6'd1) begin errors++; $display("FAIL first_tick: got %0d expected 1", ifa.seconds); end
      end
    end
    checks++;
    if (bobs !== bexp) begin errors++; $display("FAIL blink_phase: got %b expected %b", bobs, bexp); end
  endtask

  task automatic test_wrap(input logic mam);
    int nm, nh, pos;
    nm = 0; nh = 0; pos = -1;
    apply_reset();
    ifa.mins_at_max = mam;
    for (int s = 1; s <= 244; s++) begin
      step();
      if (ifa.inc_mins === 1'b1) begin nm++; pos = s; end
      if (ifa.inc_hours === 1'b1) nh++;
      if (s == 236) begin
        checks++;
        if (ifa.seconds !== 6'd59) begin errors++; $display("FAIL secs_59: got %0d expected 59", ifa.seconds); end
      end
      if (s == 240) begin
        checks++;
        if ({ifa.seconds, ifa.inc_mins, ifa.inc_hours} !== {6'd0, 1'b1, mam})
          begin errors++; $display("FAIL wrap_cycle: got secs=%0d mins=%b hours=%b expected secs=0 mins=1 hours=%b",
            ifa.seconds, ifa.inc_mins, ifa.inc_hours, mam); end
      end
    end
    checks++;
    if (nm !== 1 || pos !== 240) begin errors++; $display("FAIL wrap_mins_pulses: got %0d at step %0d expected 1 at step 240", nm, pos); end
    checks++;
    if (nh !== int'(mam)) begin errors++; $display("FAIL wrap_hours_pulses: got %0d expected %0d", nh, mam); end
  endtask

  task automatic test_set_hours();
    int ign, nh, nm, back;
    logic prev;
    ign = 0; nh = 0; nm = 0; back = 0; prev = 1'b0;
    apply_reset();
    for (int s = 1; s <= 92; s++) begin
      ifa.btn_inc = (s == 89 || s == 90);
      step();
      if (ifa.inc_mins === 1'b1 || ifa.inc_hours === 1'b1) ign++;
    end
    ifa.btn_inc = 1'b0;
    checks++;
    if (ign !== 0) begin errors++; $display("FAIL run_ignores_inc: got %0d pulses expected 0", ign); end
    checks++;
    if (ifa.seconds !== 6'd23) begin errors++; $display("FAIL secs_23: got %0d expected 23", ifa.seconds); end
    ifa.btn_mode = 1'b1;
    step();
    ifa.btn_mode = 1'b0;
    checks++;
    if (ifa.set_hours_active !== 1'b1 || ifa.set_mins_active !== 1'b0)
      begin errors++; $display("FAIL enter_set_hours: got h=%b m=%b expected h=1 m=0", ifa.set_hours_active, ifa.set_mins_active); end
    for (int s = 0; s < 12; s++) step();
    checks++;
    if (ifa.seconds !== 6'd23) begin errors++; $display("FAIL secs_frozen: got %0d expected 23", ifa.seconds); end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        ifa.btn_inc = (c < 2);
        step();
        if (ifa.inc_hours === 1'b1) begin nh++; if (prev) back++; end
        if (ifa.inc_mins === 1'b1) nm++;
        prev = ifa.inc_hours;
      end
    end
    checks++;
    if (nh !== 3 || back !== 0) begin errors++; $display("FAIL set_hours_pulses: got %0d (%0d back-to-back) expected 3 (0)", nh, back); end
    checks++;
    if (nm !== 0) begin errors++; $display("FAIL set_hours_no_mins: got %0d expected 0", nm); end
  endtask

  task automatic test_set_mins();
    mode_press();
    checks++;
    if (ifa.set_mins_active !== 1'b1 || ifa.set_hours_active !== 1'b0)
      begin errors++; $display("FAIL enter_set_mins: got m=%b h=%b expected m=1 h=0", ifa.set_mins_active, ifa.set_hours_active); end
    ifa.mins_at_max = 1'b1;
    ifa.btn_inc = 1'b1;
    step();
    ifa.btn_inc = 1'b0;
    checks++;
    if (ifa.inc_mins !== 1'b1 || ifa.inc_hours !== 1'b0)
      begin errors++; $display("FAIL set_mins_pulse: got mins=%b hours=%b expected mins=1 hours=0", ifa.inc_mins, ifa.inc_hours); end
    step();
    checks++;
    if (ifa.inc_mins !== 1'b0) begin errors++; $display("FAIL set_mins_single: got %b expected 0", ifa.inc_mins); end
    ifa.btn_mode = 1'b1;
    step();
    ifa.btn_mode = 1'b0;
    ifa.mins_at_max = 1'b0;
    checks++;
    if (ifa.set_mins_active !== 1'b0 || ifa.seconds !== 6'd0)
      begin errors++; $display("FAIL exit_to_run: got m=%b secs=%0d expected m=0 secs=0", ifa.set_mins_active, ifa.seconds); end
    // Prescaler restarted at 0, so the first tick lands exactly four cycles later.
    for (int s = 0; s < 3; s++) step();
    checks++;
    if (ifa.seconds !== 6'd0) begin errors++; $display("FAIL presc_clear_a: got %0d expected 0", ifa.seconds); end
    step();
    checks++;
    if (ifa.seconds !== 6'd1) begin errors++; $display("FAIL presc_clear_b: got %0d expected 1", ifa.seconds); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    mode_press();
    ifa.btn_mode = 1'b1;
    ifa.btn_inc = 1'b1;
    step();
    checks++;
    if ({ifa.set_mins_active, ifa.inc_hours, ifa.inc_mins} !== 3'b100)
      begin errors++; $display("FAIL simul_edge: got m=%b h_inc=%b m_inc=%b expected 1 0 0",
        ifa.set_mins_active, ifa.inc_hours, ifa.inc_mins); end
    step();
    checks++;
    if ({ifa.inc_hours, ifa.inc_mins} !== 2'b00)
      begin errors++; $display("FAIL simul_after: got %b expected 00", {ifa.inc_hours, ifa.inc_mins}); end
    ifa.btn_mode = 1'b0;
    ifa.btn_inc = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    ifa.btn_mode = 1'b1;
    step();
    ifa.btn_mode = 1'b0;
    checks++;
    if (ifb.set_hours_active !== 1'b1) begin errors++; $display("FAIL tmo_enter: got %b expected 1", ifb.set_hours_active); end
    n = 0;
    while (ifb.set_hours_active === 1'b1 && n < 20) begin
      step();
      n++;
    end
    // Entry on edge 1; ticks evaluated on edges 4 and 8, the second one expires.
    checks++;
    if (n !== 7) begin errors++; $display("FAIL tmo_cycles: got %0d expected 7", n); end
    checks++;
    if (ifb.set_mins_active !== 1'b0 || ifb.seconds !== 6'd0)
      begin errors++; $display("FAIL tmo_run: got m=%b secs=%0d expected m=0 secs=0", ifb.set_mins_active, ifb.seconds); end
  endtask

  task automatic test_reset_mid_pulse();
    int np;
    apply_reset();
    mode_press();
    mode_press();
    ifa.mins_at_max = 1'b1;
    ifa.btn_inc = 1'b1;
    step();
    checks++;
    if (ifa.inc_mins !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse: got %b expected 1", ifa.inc_mins); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifa.inc_mins, ifa.inc_hours, ifa.set_hours_active, ifa.set_mins_active, ifa.blink, ifa.seconds} !== 11'b0)
      begin errors++; $display("FAIL async_reset: got %b %b %b %b %b %0d expected all 0", ifa.inc_mins, ifa.inc_hours,
        ifa.set_hours_active, ifa.set_mins_active, ifa.blink, ifa.seconds); end
    step();
    reset_n = 1'b1;
    np = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (ifa.inc_mins === 1'b1 || ifa.inc_hours === 1'b1 || ifa.set_mins_active === 1'b1 || ifa.set_hours_active === 1'b1) np++;
    end
    checks++;
    if (np !== 0) begin errors++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", np); end
    ifa.btn_inc = 1'b0;
    ifa.mins_at_max = 1'b0;
  endtask

  task automatic test_hold_repeat();
    int nh, back, expn;
    logic prev;
`ifdef AUTO_REPEAT_EN
    expn = 4;
`else
    expn = 1;
`endif
    nh = 0; back = 0; prev = 1'b0;
    apply_reset();
    mode_press();
    ifa.btn_inc = 1'b1;
    for (int s = 0; s < HOLD + 3 * REP + 8; s++) begin
      if (s == HOLD + 3 * REP) ifa.btn_inc = 1'b0;
      step();
      if (ifa.inc_hours === 1'b1) begin nh++; if (prev) back++; end
      prev = ifa.inc_hours;
    end
    checks++;
    if (nh !== expn || back !== 0) begin errors++; $display("FAIL hold_pulses: got %0d (%0d back-to-back) expected %0d (0)", nh, back, expn); end
  endtask

  initial begin
    test_reset();
    test_wrap(1'b0);
    test_wrap(1'b1);
    test_set_hours();
    test_set_mins();
    test_simultaneous();
    test_timeout();
    test_reset_mid_pulse();
    test_hold_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
